// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet core: one-hot estado codes, attribute width and bounds,
// plus the estado decoder and the low-level alert helper.
package tamagotchi_pkg;

   localparam int ATTR_W = 8;
   localparam logic [ATTR_W-1:0] ATTR_MIN = 8'd0;
   localparam logic [ATTR_W-1:0] ATTR_MAX = 8'd255;

   localparam logic [4:0] INTRO      = 5'b00000;
   localparam logic [4:0] IDLE       = 5'b00001;
   localparam logic [4:0] DORMINDO   = 5'b00010;
   localparam logic [4:0] COMENDO    = 5'b00100;
   localparam logic [4:0] DANDO_AULA = 5'b01000;
   localparam logic [4:0] MORTO      = 5'b10000;

   typedef enum logic [2:0] {
      MODO_INTRO    = 3'd0,
      MODO_IDLE     = 3'd1,
      MODO_DORMINDO = 3'd2,
      MODO_COMENDO  = 3'd3,
      MODO_AULA     = 3'd4,
      MODO_MORTO    = 3'd5
   } modo_t;

   // Unknown and multi-hot codes fall back to plain decay.
   function automatic modo_t decodifica_estado(input logic [4:0] estado);
      case (estado)
         INTRO:      return MODO_INTRO;
         IDLE:       return MODO_IDLE;
         DORMINDO:   return MODO_DORMINDO;
         COMENDO:    return MODO_COMENDO;
         DANDO_AULA: return MODO_AULA;
         MORTO:      return MODO_MORTO;
         default:    return MODO_IDLE;
      endcase
   endfunction

   function automatic logic [2:0] calcula_alerta(
      input logic [ATTR_W-1:0] fome,
      input logic [ATTR_W-1:0] felicidade,
      input logic [ATTR_W-1:0] sono,
      input logic [ATTR_W-1:0] limiar
   );
      return {(fome < limiar), (felicidade < limiar), (sono < limiar)};
   endfunction

endpackage

// File: rtl/atributos_if.sv
// Attribute bus between the state controller (estado) and the attribute manager.
interface atributos_if;
   import tamagotchi_pkg::*;

   logic [4:0]        estado;
   logic [ATTR_W-1:0] fome;
   logic [ATTR_W-1:0] felicidade;
   logic [ATTR_W-1:0] sono;
   logic [2:0]        alerta;
   logic              tick;

   modport master (
      input  estado,
      output fome,
      output felicidade,
      output sono,
      output alerta,
      output tick
   );

   modport slave (
      output estado,
      input  fome,
      input  felicidade,
      input  sono,
      input  alerta,
      input  tick
   );

endinterface

// File: rtl/atualizador_saturado.sv
// Combinational add/subtract of one attribute, clamped to [ATTR_MIN, ATTR_MAX].
module atualizador_saturado
   import tamagotchi_pkg::*;
(
   input  logic [ATTR_W-1:0] valor,
   input  logic [ATTR_W-1:0] quantidade,
   input  logic              subtrair,
   output logic [ATTR_W-1:0] resultado
);

   logic [ATTR_W:0] soma_s;
   logic [ATTR_W:0] diferenca_s;

   assign soma_s      = {1'b0, valor} + {1'b0, quantidade};
   assign diferenca_s = {1'b0, valor} - {1'b0, quantidade};

   // The ninth bit flags overflow on add and borrow on subtract.
   always_comb begin
      resultado = valor;
      if (subtrair) begin
         resultado = diferenca_s[ATTR_W] ? ATTR_MIN : diferenca_s[ATTR_W-1:0];
      end else begin
         resultado = soma_s[ATTR_W] ? ATTR_MAX : soma_s[ATTR_W-1:0];
      end
   end

endmodule

// File: rtl/gerenciador_atributos.sv
// Attribute manager: periodic tick generator plus per-estado update of fome/felicidade/sono
// with saturating arithmetic and registered low-level alerts.
module gerenciador_atributos
   import tamagotchi_pkg::*;
#(
   parameter int TICK_CYCLES   = 4194304,
   parameter int VALOR_INICIAL = 128,
   parameter int DECAIMENTO    = 1,
   parameter int GANHO         = 16,
   parameter int LIMIAR_BAIXO  = 32
) (
   input logic        clk,
   input logic        reset,
   atributos_if.master bus
);

   localparam int                CNT_W      = $clog2(TICK_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_ULTIMO = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_UM     = CNT_W'(1);
   localparam logic [ATTR_W-1:0] VAL_INI    = ATTR_W'(VALOR_INICIAL);
   localparam logic [ATTR_W-1:0] DEC_Q      = ATTR_W'(DECAIMENTO);
   localparam logic [ATTR_W-1:0] DEC2_Q     = ATTR_W'(2 * DECAIMENTO);
   localparam logic [ATTR_W-1:0] GAN_Q      = ATTR_W'(GANHO);
   localparam logic [ATTR_W-1:0] LIM_Q      = ATTR_W'(LIMIAR_BAIXO);

   logic [CNT_W-1:0]  cnt_r;
   logic [ATTR_W-1:0] fome_r;
   logic [ATTR_W-1:0] felicidade_r;
   logic [ATTR_W-1:0] sono_r;
   logic [2:0]        alerta_r;

   modo_t             modo_s;
   logic              intro_s;
   logic              tick_s;
   logic [ATTR_W-1:0] qtd_fome_s;
   logic [ATTR_W-1:0] qtd_felicidade_s;
   logic [ATTR_W-1:0] qtd_sono_s;
   logic              sub_fome_s;
   logic              sub_felicidade_s;
   logic              sub_sono_s;
   logic [ATTR_W-1:0] res_fome_s;
   logic [ATTR_W-1:0] res_felicidade_s;
   logic [ATTR_W-1:0] res_sono_s;
   logic [ATTR_W-1:0] fome_n_s;
   logic [ATTR_W-1:0] felicidade_n_s;
   logic [ATTR_W-1:0] sono_n_s;

   assign modo_s  = decodifica_estado(bus.estado);
   assign intro_s = (modo_s == MODO_INTRO);
   // tick marks exactly the edge at which attributes change, so reset and INTRO suppress it.
   assign tick_s  = (cnt_r == CNT_ULTIMO) && !reset && !intro_s;

   // Amount and direction for each attribute in the current estado.
   always_comb begin
      qtd_fome_s       = DEC_Q;
      qtd_felicidade_s = DEC_Q;
      qtd_sono_s       = DEC_Q;
      sub_fome_s       = 1'b1;
      sub_felicidade_s = 1'b1;
      sub_sono_s       = 1'b1;
      case (modo_s)
         MODO_COMENDO: begin
            qtd_fome_s = GAN_Q;
            sub_fome_s = 1'b0;
         end
         MODO_DORMINDO: begin
            qtd_sono_s = GAN_Q;
            sub_sono_s = 1'b0;
         end
         MODO_AULA: begin
            qtd_felicidade_s = GAN_Q;
            sub_felicidade_s = 1'b0;
            qtd_sono_s       = DEC2_Q;
         end
         default: begin
            qtd_fome_s = DEC_Q;
         end
      endcase
   end

   atualizador_saturado u_sat_fome (
      .valor      (fome_r),
      .quantidade (qtd_fome_s),
      .subtrair   (sub_fome_s),
      .resultado  (res_fome_s)
   );

   atualizador_saturado u_sat_felicidade (
      .valor      (felicidade_r),
      .quantidade (qtd_felicidade_s),
      .subtrair   (sub_felicidade_s),
      .resultado  (res_felicidade_s)
   );

   atualizador_saturado u_sat_sono (
      .valor      (sono_r),
      .quantidade (qtd_sono_s),
      .subtrair   (sub_sono_s),
      .resultado  (res_sono_s)
   );

   // Next attribute values: reload in INTRO, update on tick unless MORTO, otherwise hold.
   always_comb begin
      fome_n_s       = fome_r;
      felicidade_n_s = felicidade_r;
      sono_n_s       = sono_r;
      if (intro_s) begin
         fome_n_s       = VAL_INI;
         felicidade_n_s = VAL_INI;
         sono_n_s       = VAL_INI;
      end else if (tick_s && (modo_s != MODO_MORTO)) begin
         fome_n_s       = res_fome_s;
         felicidade_n_s = res_felicidade_s;
         sono_n_s       = res_sono_s;
      end else begin
         fome_n_s       = fome_r;
         felicidade_n_s = felicidade_r;
         sono_n_s       = sono_r;
      end
   end

   // Tick counter, attribute registers and alerts derived from the same next values.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r        <= CNT_ZERO;
         fome_r       <= VAL_INI;
         felicidade_r <= VAL_INI;
         sono_r       <= VAL_INI;
         alerta_r     <= calcula_alerta(VAL_INI, VAL_INI, VAL_INI, LIM_Q);
      end else begin
         if (intro_s || (cnt_r == CNT_ULTIMO)) begin
            cnt_r <= CNT_ZERO;
         end else begin
            cnt_r <= cnt_r + CNT_UM;
         end
         fome_r       <= fome_n_s;
         felicidade_r <= felicidade_n_s;
         sono_r       <= sono_n_s;
         alerta_r     <= calcula_alerta(fome_n_s, felicidade_n_s, sono_n_s, LIM_Q);
      end
   end

   assign bus.fome       = fome_r;
   assign bus.felicidade = felicidade_r;
   assign bus.sono       = sono_r;
   assign bus.alerta     = alerta_r;
   assign bus.tick       = tick_s;

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Directed bench for gerenciador_atributos with a 4-cycle tick; expected values are hand-computed.
module tb_gerenciador_atributos;
   import tamagotchi_pkg::*;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   atributos_if bus ();

   gerenciador_atributos #(
      .TICK_CYCLES   (4),
      .VALOR_INICIAL (128),
      .DECAIMENTO    (1),
      .GANHO         (16),
      .LIMIAR_BAIXO  (32)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $error("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic avanca(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_attr(input string tag, input int f, input int fe, input int s);
      chk({tag, ".fome"},       {24'd0, bus.fome},       f);
      chk({tag, ".felicidade"}, {24'd0, bus.felicidade}, fe);
      chk({tag, ".sono"},       {24'd0, bus.sono},       s);
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      reset      = 1'b1;
      bus.estado = IDLE;
      avanca(2);
      chk_attr("reset", 128, 128, 128);
      chk("reset.alerta", {29'd0, bus.alerta}, 0);
      chk("reset.tick", {31'd0, bus.tick}, 0);

      // IDLE decay; counter 0 on the release cycle, tick on the fourth cycle
      reset = 1'b0;
      chk("c1.tick", {31'd0, bus.tick}, 0);
      avanca(2);
      chk("c3.tick", {31'd0, bus.tick}, 0);
      avanca(1);
      chk("c4.tick", {31'd0, bus.tick}, 1);
      chk("c4.fome_pre", {24'd0, bus.fome}, 128);
      avanca(1);
      chk_attr("idle_t1", 127, 127, 127);
      chk("c5.tick", {31'd0, bus.tick}, 0);
      avanca(4 * 95);
      chk_attr("idle_t96", 32, 32, 32);
      chk("idle_t96.alerta", {29'd0, bus.alerta}, 0);
      avanca(4);
      chk_attr("idle_t97", 31, 31, 31);
      chk("idle_t97.alerta", {29'd0, bus.alerta}, 7);

      // COMENDO from 128: fome saturates at tick 8
      bus.estado = INTRO;
      avanca(1);
      chk_attr("intro1", 128, 128, 128);
      bus.estado = COMENDO;
      avanca(32);
      chk("comendo_t8.fome", {24'd0, bus.fome}, 255);
      avanca(4);
      chk_attr("comendo_t9", 255, 119, 119);

      // multi-hot code behaves as IDLE
      bus.estado = 5'b00110;
      avanca(4);
      chk_attr("multihot", 254, 118, 118);

      // drive sono to 0 with felicidade high, then shape 0/128/3
      bus.estado = INTRO;
      avanca(1);
      bus.estado = DANDO_AULA;
      avanca(4 * 64);
      chk_attr("aula_t64", 64, 255, 0);
      bus.estado = IDLE;
      avanca(4 * 113);
      chk_attr("idle_t113", 0, 142, 0);
      bus.estado = DORMINDO;
      avanca(4);
      chk_attr("dorm_t1", 0, 141, 16);
      bus.estado = IDLE;
      avanca(4 * 13);
      chk_attr("idle_t13", 0, 128, 3);
      bus.estado = DANDO_AULA;
      avanca(4);
      chk_attr("aula_s1", 0, 144, 1);
      avanca(4);
      chk_attr("aula_s0", 0, 160, 0);
      chk("aula_s0.alerta", {29'd0, bus.alerta}, 5);

      // shape 0/50/70 then freeze in MORTO
      bus.estado = IDLE;
      avanca(4 * 95);
      chk_attr("idle_t95", 0, 65, 0);
      bus.estado = DORMINDO;
      avanca(4 * 5);
      chk_attr("dorm_t5", 0, 60, 80);
      bus.estado = IDLE;
      avanca(4 * 10);
      chk_attr("pre_morto", 0, 50, 70);
      bus.estado = MORTO;
      avanca(3);
      chk("morto.tick", {31'd0, bus.tick}, 1);
      avanca(37);
      chk_attr("morto_t10", 0, 50, 70);
      chk("morto.alerta", {29'd0, bus.alerta}, 4);

      // INTRO reloads next cycle and holds the counter; first tick 4 cycles after release
      bus.estado = INTRO;
      avanca(1);
      chk_attr("intro2", 128, 128, 128);
      chk("intro2.alerta", {29'd0, bus.alerta}, 0);
      avanca(3);
      chk("intro_hold.tick", {31'd0, bus.tick}, 0);
      bus.estado = IDLE;
      avanca(2);
      chk("rel_c3.tick", {31'd0, bus.tick}, 0);
      avanca(1);
      chk("rel_c4.tick", {31'd0, bus.tick}, 1);
      avanca(1);
      chk_attr("rel_t1", 127, 127, 127);

      // one-cycle COMENDO glitch between ticks applies no gain
      avanca(1);
      bus.estado = COMENDO;
      avanca(1);
      bus.estado = IDLE;
      avanca(1);
      chk("glitch.tick", {31'd0, bus.tick}, 1);
      avanca(1);
      chk_attr("glitch", 126, 126, 126);

      // reset on the tick cycle suppresses the pulse and restarts the counter
      avanca(3);
      reset = 1'b1;
      #1;
      chk("rst_tick.tick", {31'd0, bus.tick}, 0);
      avanca(1);
      chk_attr("rst_tick", 128, 128, 128);
      chk("rst_hold.tick", {31'd0, bus.tick}, 0);
      reset = 1'b0;
      avanca(2);
      chk("rst_c3.tick", {31'd0, bus.tick}, 0);
      avanca(1);
      chk("rst_c4.tick", {31'd0, bus.tick}, 1);
      avanca(1);
      chk_attr("rst_t1", 127, 127, 127);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
